// File: rtl/n64_controller_responder.sv
// Controller-side N64 single-wire responder: decodes console command bytes and
// answers status (0x00/0xFF) and poll (0x01) with the standard response frames.
module n64_controller_responder #(
  parameter int          CYC_PER_US    = 100,
  parameter logic [23:0] STATUS_WORD   = 24'h050002,
  parameter int          RX_TIMEOUT_US = 8
) (
  input  logic        PCLK,
  input  logic        PRESET,
  inout  logic        data_line,
  input  logic [15:0] buttons,
  input  logic [7:0]  joy_x,
  input  logic [7:0]  joy_y,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        busy,
  output logic        rx_err
);

  localparam int TW = $clog2((18 + RX_TIMEOUT_US) * CYC_PER_US + 1);
  localparam logic [TW-1:0] T_1US   = TW'(CYC_PER_US);
  localparam logic [TW-1:0] T_2US   = TW'(2 * CYC_PER_US);
  localparam logic [TW-1:0] T_3US   = TW'(3 * CYC_PER_US);
  localparam logic [TW-1:0] T_3P5US = TW'((7 * CYC_PER_US) / 2);
  localparam logic [TW-1:0] T_4US   = TW'(4 * CYC_PER_US);
  localparam logic [TW-1:0] T_TMO   = TW'((2 + RX_TIMEOUT_US) * CYC_PER_US);
  localparam logic [TW-1:0] T_16US  = TW'(16 * CYC_PER_US);

  typedef enum logic [2:0] {
    IDLE, RX_BIT, RX_STOP, GAP, TX_BIT, TX_STOP, IGNORE
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [5:0]    bitcnt_q, bitcnt_d;
  logic [5:0]    tx_len_q, tx_len_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic [7:0]    cmd_byte_q, cmd_byte_d;
  logic [31:0]   payload_q, payload_d;
  logic          sampled_q, sampled_d;
  logic          drive_q, drive_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          rx_err_q, rx_err_d;
  logic          sync1_q, line_s_q, line_prev_q;
  logic          fall;

  assign fall      = line_prev_q & ~line_s_q;
  assign data_line = drive_q ? 1'b0 : 1'bz;
  assign cmd_valid = cmd_valid_q;
  assign cmd_byte  = cmd_byte_q;
  assign busy      = (state_q != IDLE);
  assign rx_err    = rx_err_q;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + 1'b1;
    bitcnt_d    = bitcnt_q;
    tx_len_d    = tx_len_q;
    rx_byte_d   = rx_byte_q;
    cmd_byte_d  = cmd_byte_q;
    payload_d   = payload_q;
    sampled_d   = sampled_q;
    drive_d     = 1'b0;
    cmd_valid_d = 1'b0;
    rx_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (fall) begin
          state_d   = RX_BIT;
          timer_d   = TW'(1);
          bitcnt_d  = '0;
          rx_byte_d = '0;
          sampled_d = 1'b0;
        end
      end

      // Timer counts from the synchronized falling edge of the current cell.
      RX_BIT: begin
        if (!sampled_q) begin
          if (timer_q == T_2US) begin
            rx_byte_d = {rx_byte_q[6:0], line_s_q};
            bitcnt_d  = bitcnt_q + 6'd1;
            sampled_d = 1'b1;
          end
        end else if (fall) begin
          timer_d   = TW'(1);
          sampled_d = 1'b0;
          if (bitcnt_q == 6'd8) state_d = RX_STOP;
        end else if (timer_q == T_3P5US && !line_s_q) begin
          rx_err_d = 1'b1;
          state_d  = IGNORE;
          timer_d  = '0;
        end else if (timer_q == T_TMO) begin
          rx_err_d = 1'b1;
          state_d  = IDLE;
        end
      end

      RX_STOP: begin
        if (timer_q == T_2US) begin
          timer_d = '0;
          if (!line_s_q) begin
            rx_err_d = 1'b1;
            state_d  = IGNORE;
          end else begin
            cmd_byte_d  = rx_byte_q;
            cmd_valid_d = 1'b1;
            if (rx_byte_q == 8'h00 || rx_byte_q == 8'hFF) begin
              state_d   = GAP;
              payload_d = {STATUS_WORD, 8'h00};
              tx_len_d  = 6'd24;
            end else if (rx_byte_q == 8'h01) begin
              state_d   = GAP;
              payload_d = {buttons, joy_x, joy_y};
              tx_len_d  = 6'd32;
            end else begin
              state_d = IGNORE;
            end
          end
        end
      end

      GAP: begin
        if (fall) begin
          rx_err_d = 1'b1;
          state_d  = IGNORE;
          timer_d  = '0;
        end else if (!line_s_q) begin
          timer_d = '0;
        end else if (timer_q == T_2US - 1'b1) begin
          state_d  = TX_BIT;
          timer_d  = '0;
          bitcnt_d = '0;
        end
      end

      // Drive is registered, so every cell is uniformly delayed one cycle.
      TX_BIT: begin
        drive_d = (timer_q < (payload_q[31] ? T_1US : T_3US));
        if (timer_q == T_4US - 1'b1) begin
          timer_d   = '0;
          payload_d = {payload_q[30:0], 1'b0};
          bitcnt_d  = bitcnt_q + 6'd1;
          if (bitcnt_q == tx_len_q - 6'd1) state_d = TX_STOP;
        end
      end

      TX_STOP: begin
        drive_d = (timer_q < T_2US);
        if (timer_q > T_2US && line_s_q) begin
          state_d = IDLE;
        end else if (timer_q == T_4US) begin
          rx_err_d = 1'b1;
          state_d  = IDLE;
        end
      end

      IGNORE: begin
        if (!line_s_q) begin
          timer_d = '0;
        end else if (timer_q == T_16US - 1'b1) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bitcnt_q    <= '0;
      tx_len_q    <= '0;
      rx_byte_q   <= '0;
      cmd_byte_q  <= '0;
      payload_q   <= '0;
      sampled_q   <= 1'b0;
      drive_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      rx_err_q    <= 1'b0;
      sync1_q     <= 1'b1;
      line_s_q    <= 1'b1;
      line_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bitcnt_q    <= bitcnt_d;
      tx_len_q    <= tx_len_d;
      rx_byte_q   <= rx_byte_d;
      cmd_byte_q  <= cmd_byte_d;
      payload_q   <= payload_d;
      sampled_q   <= sampled_d;
      drive_q     <= drive_d;
      cmd_valid_q <= cmd_valid_d;
      rx_err_q    <= rx_err_d;
      sync1_q     <= data_line;
      line_s_q    <= sync1_q;
      line_prev_q <= line_s_q;
    end
  end

endmodule

// File: tb/tb_n64_controller_responder.sv
// Scoreboard bench for n64_controller_responder: console-side stimulus pushes
// expected events; a monitor decodes cmd_valid/rx_err pulses and response frames.
module tb_n64_controller_responder;

  localparam int US = 4;
  localparam logic [1:0] EV_CMD   = 2'd1;
  localparam logic [1:0] EV_FRAME = 2'd2;
  localparam logic [1:0] EV_ERR   = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [39:0] val;
  } ev_t;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        console_low = 1'b0;
  logic [15:0] buttons = 16'h0000;
  logic [7:0]  joy_x = 8'h00;
  logic [7:0]  joy_y = 8'h00;
  wire         data_line;
  wire         cmd_valid;
  wire  [7:0]  cmd_byte;
  wire         busy;
  wire         rx_err;

  int  assertCount = 0;
  int  failCount = 0;
  ev_t expQ[$];

  // monitor state
  int          lowCnt = 0;
  int          sinceFall = 0;
  int          nBits = 0;
  logic        inFrame = 1'b0;
  logic [31:0] frameVal = 32'h0;

  // stimulus scratch
  int   falls = 0;
  int   waited = 0;
  logic prevLow = 1'b0;

  pullup (data_line);
  assign data_line = console_low ? 1'b0 : 1'bz;
  wire dutLow = (data_line === 1'b0) && !console_low;

  always #5 PCLK = ~PCLK;

  n64_controller_responder #(.CYC_PER_US(US)) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .data_line (data_line),
    .buttons   (buttons),
    .joy_x     (joy_x),
    .joy_y     (joy_y),
    .cmd_valid (cmd_valid),
    .cmd_byte  (cmd_byte),
    .busy      (busy),
    .rx_err    (rx_err)
  );

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string name, input logic [47:0] actual,
                             input logic [47:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic [1:0] kind, input logic [39:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    expQ.push_back(e);
  endtask

  task automatic observe(input string name, input logic [1:0] kind, input logic [39:0] val);
    ev_t e;
    if (expQ.size() == 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL unexpected_%s: got 0x%0h, expected no event", name, val);
    end else begin
      e = expQ.pop_front();
      checkOutput(name, {6'd0, kind, val}, {6'd0, e.kind, e.val});
    end
  endtask

  // One console bit cell: '1' = 1 us low/3 us high, '0' = 3 us low/1 us high.
  task automatic consoleBit(input logic b);
    @(negedge PCLK);
    console_low = 1'b1;
    repeat ((b ? 1 : 3) * US) @(negedge PCLK);
    console_low = 1'b0;
    repeat ((b ? 3 : 1) * US - 1) @(negedge PCLK);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) consoleBit(b[i]);
  endtask

  task automatic consoleStop();
    @(negedge PCLK);
    console_low = 1'b1;
    repeat (US) @(negedge PCLK);
    console_low = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    int n = 0;
    while ((busy || expQ.size() != 0) && n < budget) begin
      @(negedge PCLK);
      n++;
    end
    checkOutput({name, "_done"}, {47'd0, (busy || expQ.size() != 0)}, 48'd0);
    repeat (10) @(negedge PCLK);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_line"}, {47'd0, data_line === 1'b1}, 48'd1);
    checkOutput({tag, "_busy"}, {47'd0, busy}, 48'd0);
    checkOutput({tag, "_cmd_valid"}, {47'd0, cmd_valid}, 48'd0);
    checkOutput({tag, "_rx_err"}, {47'd0, rx_err}, 48'd0);
    checkOutput({tag, "_cmd_byte"}, {40'd0, cmd_byte}, 48'd0);
  endtask

  // Monitor: pops the scoreboard on every DUT output event and decodes the
  // responder's own low pulses into frames, checking exact cell spacing.
  initial begin
    forever begin
      @(negedge PCLK);
      if (PRESET) begin
        lowCnt    = 0;
        nBits     = 0;
        inFrame   = 1'b0;
        frameVal  = 32'h0;
        sinceFall = 0;
      end else begin
        if (cmd_valid) observe("cmd", EV_CMD, {32'd0, cmd_byte});
        if (rx_err) observe("rx_err", EV_ERR, 40'd0);
        if (dutLow) begin
          if (lowCnt == 0) begin
            if (inFrame) checkOutput("cell_period", 48'(sinceFall), 48'(4 * US));
            inFrame   = 1'b1;
            sinceFall = 0;
          end
          lowCnt++;
        end else if (lowCnt != 0) begin
          if (lowCnt == US) begin
            frameVal = {frameVal[30:0], 1'b1};
            nBits++;
          end else if (lowCnt == 3 * US) begin
            frameVal = {frameVal[30:0], 1'b0};
            nBits++;
          end else if (lowCnt == 2 * US) begin
            observe("frame", EV_FRAME, {8'(nBits), frameVal});
            nBits    = 0;
            frameVal = 32'h0;
            inFrame  = 1'b0;
          end else begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL pulse_len: got %0d cycles, expected %0d, %0d or %0d",
                     lowCnt, US, 2 * US, 3 * US);
          end
          lowCnt = 0;
        end
        sinceFall++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (5) @(negedge PCLK);
    checkResetOutputs("reset");
    PRESET = 1'b0;
    repeat (10) @(negedge PCLK);

    // Status request 0x00
    pushExp(EV_CMD, 40'h00);
    pushExp(EV_FRAME, {8'd24, 32'h0005_0002});
    applyStimulus(8'h00);
    consoleStop();
    waitDone("status00", 2000);
    checkOutput("status00_cmd_byte", {40'd0, cmd_byte}, 48'h00);

    // Poll 0x01; inputs change mid-frame and must not affect it
    buttons = 16'h8001;
    joy_x   = 8'h7F;
    joy_y   = 8'h80;
    pushExp(EV_CMD, 40'h01);
    pushExp(EV_FRAME, {8'd32, 32'h8001_7F80});
    applyStimulus(8'h01);
    consoleStop();
    repeat (200) @(negedge PCLK);
    buttons = 16'h0000;
    joy_x   = 8'h00;
    joy_y   = 8'h00;
    waitDone("poll", 2000);

    // Reset command 0xFF
    pushExp(EV_CMD, 40'hFF);
    pushExp(EV_FRAME, {8'd24, 32'h0005_0002});
    applyStimulus(8'hFF);
    consoleStop();
    waitDone("reset_ff", 2000);
    checkOutput("reset_ff_cmd_byte", {40'd0, cmd_byte}, 48'hFF);

    // Unsupported 0x02 with two address bytes: accepted, then ignored
    pushExp(EV_CMD, 40'h02);
    applyStimulus(8'h02);
    applyStimulus(8'h80);
    applyStimulus(8'h01);
    consoleStop();
    repeat (60) @(negedge PCLK);
    checkOutput("ignore_busy_held", {47'd0, busy}, 48'd1);
    repeat (12) @(negedge PCLK);
    checkOutput("ignore_busy_released", {47'd0, busy}, 48'd0);
    waitDone("ignore", 200);

    // Truncated command: four bits then the line stays high
    pushExp(EV_ERR, 40'h0);
    consoleBit(1'b1);
    consoleBit(1'b0);
    consoleBit(1'b1);
    consoleBit(1'b0);
    repeat (4 * US) @(negedge PCLK);
    checkOutput("trunc_busy_before_timeout", {47'd0, busy}, 48'd1);
    waitDone("trunc", 200);
    checkOutput("trunc_cmd_byte_held", {40'd0, cmd_byte}, 48'h02);

    // Reset in the middle of bit 10 of a poll response
    buttons = 16'h8001;
    joy_x   = 8'h7F;
    joy_y   = 8'h80;
    pushExp(EV_CMD, 40'h01);
    applyStimulus(8'h01);
    consoleStop();
    falls   = 0;
    waited  = 0;
    prevLow = 1'b0;
    while (falls < 11 && waited < 2000) begin
      @(negedge PCLK);
      if (dutLow && !prevLow) falls++;
      prevLow = dutLow;
      waited++;
    end
    checkOutput("reach_bit10", 48'(falls), 48'd11);
    repeat (2) @(negedge PCLK);
    PRESET = 1'b1;
    @(posedge PCLK);
    #1;
    checkResetOutputs("midtx_reset");
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    repeat (20) @(negedge PCLK);

    // Fresh status request after the reset
    pushExp(EV_CMD, 40'h00);
    pushExp(EV_FRAME, {8'd24, 32'h0005_0002});
    applyStimulus(8'h00);
    consoleStop();
    waitDone("after_reset", 2000);

    checkOutput("scoreboard_empty", 48'(expQ.size()), 48'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/n64_controller_responder.md
Name: n64_controller_responder

Overview:
- Acts as the controller end of the N64 single-wire protocol, so the fabric can emulate a controller attached to a console.
- Decodes console command bytes on the open-drain data_line.
- Answers status/reset (0x00/0xFF) and poll (0x01) commands with the standard response frames.
- Sits in fabric on the MSS FAB_CLK beside controller_interface; button/stick values come from fabric logic or MSS registers.

Parameters:
- CYC_PER_US, 100, PCLK cycles per microsecond. All protocol timing derives from this. Benches use 4.
- STATUS_WORD, 24'h050002, 3-byte status response, MSB first.
- RX_TIMEOUT_US, 8, maximum high time between bits inside a command before abort.

Ports:
- PCLK  input  1  fabric clock
- PRESET  input  1  synchronous, active-high reset
- data_line  inout  1  open-drain N64 line; driven 0 when pulling low, else high-Z
- buttons  input  16  button word: A,B,Z,Start,Dup,Ddn,Dlf,Drt,0,0,L,R,Cup,Cdn,Clf,Crt, bit15 first on wire
- joy_x  input  8  signed stick X
- joy_y  input  8  signed stick Y
- cmd_valid  output  1  one-cycle pulse when a command byte plus stop bit has been received
- cmd_byte  output  8  last received command; holds until the next cmd_valid
- busy  output  1  high from the first falling edge of a command until response stop is done, or until IGNORE/abort exits
- rx_err  output  1  one-cycle pulse on a malformed or timed-out command

Behaviour:
- Input path: data_line passes through a 2-FF synchronizer to line_s. Falling edge = line_s 1→0. All timing below is measured from the synchronized edge.
- Wire encoding: bit cell T=4 us.
  - '0' = 3 us low, 1 us high.
  - '1' = 1 us low, 3 us high.
  - Console stop = 1 us low then release.
  - Responder stop = 2 us low then release.
- Reset values: data_line released (Z); cmd_valid=0; cmd_byte=8'h00; busy=0; rx_err=0; FSM=IDLE; all counters 0.
- Reset takes effect on the next PCLK edge in any state. This includes mid-TX: the line is released within 1 cycle and the response is not resumed.
- States:
  - IDLE: on falling edge → RX_BIT; bitcnt=0; busy=1.
  - RX_BIT: at 2 us after the falling edge, sample line_s; bit = sampled value. Shift into the byte MSB first and increment bitcnt. Then wait for the next falling edge.
    - If bitcnt==8 when that edge arrives → RX_STOP.
    - If no falling edge within RX_TIMEOUT_US of the sample point → rx_err pulse, IDLE, busy=0.
    - If the line is still low at the 3.5 us point (over-long low) → rx_err, IGNORE.
  - RX_STOP: at 2 us, line_s must be 1, otherwise rx_err → IGNORE. On stop OK, cmd_byte is updated and cmd_valid pulses that cycle. Then:
    - 0x00 or 0xFF → GAP with 24-bit payload STATUS_WORD.
    - 0x01 → GAP with the 32-bit payload {buttons,joy_x,joy_y}, latched in this cycle.
    - Any other value → IGNORE.
  - GAP: wait until line_s has been high continuously for 2 us → TX_BIT. A falling edge during GAP → rx_err, IGNORE.
  - TX_BIT: drive each payload bit MSB first with the encoding above. Bit cells are back-to-back, with exact cell length 4*CYC_PER_US cycles. After the last bit → TX_STOP.
  - TX_STOP: drive low 2*CYC_PER_US cycles, release. Wait for line_s=1 (max 2 us, else rx_err), then → IDLE, busy=0.
  - IGNORE: line released; stay until line_s is high continuously for 16 us, then → IDLE, busy=0. This covers multi-byte commands 0x02/0x03.
- Payload latching: inputs are sampled once, in the RX_STOP cycle. Changes to buttons/joy_* during TX do not affect the frame in flight.
- The responder never drives during RX or IGNORE. The console side is assumed never to drive during TX; collisions are not detected.
- Counter widths: the timer must hold 16*CYC_PER_US. The bit counter is 6 bits.

Test Plan:
- Status (CYC_PER_US=4): console sends 0x00 + stop → cmd_valid one cycle with cmd_byte=00. After 2 us idle, the line carries 0x05,0x00,0x02 MSB first (e.g. first bits 0,0,0,0,0,1,0,1 with 3 us/1 us lows), then a 2 us low stop; busy falls once the line is high.
- Poll: buttons=16'h8001, joy_x=8'h7F, joy_y=8'h80, send 0x01 → 32 bits 1000_0000_0000_0001_0111_1111_1000_0000 plus stop. Changing buttons to 0 mid-frame leaves the frame unchanged.
- Reset cmd 0xFF → same 3-byte status frame as 0x00; cmd_byte=FF.
- Unsupported 0x02 followed by 2 address bytes → cmd_valid with cmd_byte=02, no drive at any time, rx_err=0. Return to IDLE 16 us after the last edge.
- Truncated command (4 bits then line high) → rx_err pulse 8 us after the 4th sample point, no drive, busy=0, cmd_valid never asserts.
- PRESET asserted at bit 10 of a poll response → data_line Z on the next cycle, outputs at reset values. A fresh 0x00 command afterwards gets a correct status frame.
